mod_writeback: RTL and testbench

Writeback stage directly downstream of the execute ALU. It latches execute results into an EX/WB pipeline register and drives the single register-file write port. It maintains the architectural RFLAGS copy that is fed back to execute as rflags_seq, emits fetch-resteer pulses for taken jumps, and releases scoreboard dependencies. Two-write results (IMUL, RDX:RAX) are serialised through the one write port, which stalls execute for one cycle.

---
 rtl/mod_writeback_pkg.sv | 87 ++++++++
 rtl/mod_wb_decode.sv | 32 +++
 rtl/mod_writeback.sv | 111 +++++++++++
 tb/tb_mod_writeback.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mod_writeback_pkg.sv
// Shared types and constants for the writeback stage: flag layout, stage
// structs, opcode classes and a few small helpers.
package mod_writeback_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;

    localparam logic [7:0] OPC_IMUL    = 8'd247;
    localparam logic [7:0] OPC_JE      = 8'd116;
    localparam logic [7:0] OPC_JGE     = 8'd125;
    localparam logic [7:0] OPC_JMP     = 8'd141;
    localparam logic [7:0] OPC_SYSCALL = 8'd5;
    localparam logic [7:0] OPC_PUSH_LO = 8'd80;
    localparam logic [7:0] OPC_PUSH_HI = 8'd87;

    localparam logic [3:0] REG_RAX     = 4'd0;
    localparam logic [3:0] REG_RDX     = 4'd2;
    localparam logic [3:0] EXT_CMP     = 4'd7;
    localparam logic [1:0] DEP_REGBYTE = 2'd2;

    localparam logic [XLEN-1:0] RESET_FLAGS = 64'h2;

    typedef struct packed {
        logic [51:0] rsvd_hi;
        logic        of;
        logic        df;
        logic        if_f;
        logic        tf;
        logic        sf;
        logic        zf;
        logic        res_3;
        logic        af;
        logic        res_2;
        logic        pf;
        logic        res_1;
        logic        cf;
    } flags_reg;

    typedef struct packed {
        logic [XLEN-1:0] rip;
        logic [1:0]      dep;
        logic            sim_end;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] alu_ext_result;
        logic [3:0]      regbyte;
        logic [3:0]      rmbyte;
        logic [7:0]      opcode;
        logic            jump_flag;
        logic [XLEN-1:0] rflags;
        logic            flags_we;
    } MEM_EX;

    // Only what the second (high-half) write cycle still needs is kept here.
    typedef struct packed {
        logic            valid;
        logic            sim_end;
        logic [XLEN-1:0] ext_result;
    } EX_WB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_DONE
    } wb_state_t;

    function automatic logic opcode_group(input logic [7:0] op);
        return op inside {8'd128, 8'd129, 8'd131};
    endfunction

    // Scoreboard bits are indexed MSB-first: register 0 owns the top bit.
    function automatic logic [NREGS-1:0] dep_mask(input logic [3:0] addr);
        logic [NREGS-1:0] top_bit;
        top_bit = '0;
        top_bit[NREGS-1] = 1'b1;
        return top_bit >> addr;
    endfunction

    function automatic logic [XLEN-1:0] sanitize_flags(input logic [XLEN-1:0] f);
        flags_reg r;
        r = f;
        r.res_1 = 1'b1;
        r.res_2 = 1'b0;
        r.res_3 = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mod_wb_decode.sv
// Combinational opcode classification: does the beat write, where to, and
// does it need the second RDX write.
module mod_wb_decode
    import mod_writeback_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [3:0] regbyte,
    input  logic [3:0] rmbyte,
    input  logic [1:0] dep,
    output logic       write_en,
    output logic [3:0] dest,
    output logic       is_imul
);

    logic no_write;

    always_comb begin
        is_imul  = (opcode == OPC_IMUL);
        no_write = (opcode == OPC_JE) || (opcode == OPC_JGE) || (opcode == OPC_JMP)
                || (opcode inside {[OPC_PUSH_LO:OPC_PUSH_HI]})
                || (opcode == OPC_SYSCALL)
                || (opcode_group(opcode) && (regbyte == EXT_CMP));
        write_en = !no_write;
        if (is_imul)
            dest = REG_RAX;
        else if (dep == DEP_REGBYTE)
            dest = regbyte;
        else
            dest = rmbyte;
    end

endmodule

// File: rtl/mod_writeback.sv
// Writeback stage: EX/WB register, single register-file write port with
// IMUL serialisation, architectural RFLAGS, redirects and scoreboard release.
module mod_writeback
    import mod_writeback_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid_in,
    output logic            wb_ready,
    input  logic [XLEN-1:0] rip_in,
    input  logic [1:0]      dep_in,
    input  logic            sim_end_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] alu_ext_result_in,
    input  logic [3:0]      regbyte_in,
    input  logic [3:0]      rmbyte_in,
    input  logic [7:0]      opcode_in,
    input  logic            jump_flag_in,
    input  logic [XLEN-1:0] rflags_in,
    input  logic            flags_we_in,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] rflags_seq,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [NREGS-1:0] dep_clear,
    output logic            sim_done
);

    wb_state_t  state;
    EX_WB       ex_wb;
    logic       dec_write_en;
    logic [3:0] dec_dest;
    logic       dec_is_imul;
    logic       unused_rip;

    assign unused_rip = ^rip_in;

    mod_wb_decode u_decode (
        .opcode   (opcode_in),
        .regbyte  (regbyte_in),
        .rmbyte   (rmbyte_in),
        .dep      (dep_in),
        .write_en (dec_write_en),
        .dest     (dec_dest),
        .is_imul  (dec_is_imul)
    );

    // Only IDLE can take a beat; HIGH owns the write port, DONE is terminal.
    assign wb_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            ex_wb          <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            rflags_seq     <= RESET_FLAGS;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            dep_clear      <= '0;
            sim_done       <= 1'b0;
        end else begin
            rf_we          <= 1'b0;
            dep_clear      <= '0;
            redirect_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wb_valid_in) begin
                        ex_wb <= '{valid: 1'b1, sim_end: sim_end_in,
                                   ext_result: alu_ext_result_in};
                        if (flags_we_in)
                            rflags_seq <= sanitize_flags(rflags_in);
                        if (jump_flag_in) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= alu_result_in;
                        end else if (dec_write_en) begin
                            rf_we     <= 1'b1;
                            rf_waddr  <= dec_dest;
                            rf_wdata  <= alu_result_in;
                            dep_clear <= dep_mask(dec_dest);
                        end
                        if (dec_is_imul && !jump_flag_in)
                            state <= S_HIGH;
                        else if (sim_end_in)
                            state <= S_DONE;
                    end else begin
                        ex_wb.valid <= 1'b0;
                    end
                end
                S_HIGH: begin
                    if (ex_wb.valid) begin
                        rf_we     <= 1'b1;
                        rf_waddr  <= REG_RDX;
                        rf_wdata  <= ex_wb.ext_result;
                        dep_clear <= dep_mask(REG_RDX);
                    end
                    ex_wb.valid <= 1'b0;
                    state       <= ex_wb.sim_end ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    sim_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_writeback.sv
// Directed bench for mod_writeback: hand-computed expectations for plain
// writes, IMUL serialisation, CMP/flags, jumps, reset mid-IMUL and sim_end.
module tb_mod_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic        wb_ready;
    logic [63:0] rip_in;
    logic [1:0]  dep_in;
    logic        sim_end_in;
    logic [63:0] alu_result_in;
    logic [63:0] alu_ext_result_in;
    logic [3:0]  regbyte_in;
    logic [3:0]  rmbyte_in;
    logic [7:0]  opcode_in;
    logic        jump_flag_in;
    logic [63:0] rflags_in;
    logic        flags_we_in;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] rflags_seq;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [15:0] dep_clear;
    logic        sim_done;

    int tests_run = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    mod_writeback dut (
        .clk               (clk),
        .reset             (reset),
        .wb_valid_in       (wb_valid_in),
        .wb_ready          (wb_ready),
        .rip_in            (rip_in),
        .dep_in            (dep_in),
        .sim_end_in        (sim_end_in),
        .alu_result_in     (alu_result_in),
        .alu_ext_result_in (alu_ext_result_in),
        .regbyte_in        (regbyte_in),
        .rmbyte_in         (rmbyte_in),
        .opcode_in         (opcode_in),
        .jump_flag_in      (jump_flag_in),
        .rflags_in         (rflags_in),
        .flags_we_in       (flags_we_in),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rflags_seq        (rflags_seq),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .dep_clear         (dep_clear),
        .sim_done          (sim_done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one beat's inputs, then advance one clock and settle past the edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] op,
                                 input logic [3:0] regb, input logic [3:0] rmb,
                                 input logic [1:0] dep, input logic [63:0] res,
                                 input logic [63:0] ext, input logic jump,
                                 input logic fwe, input logic [63:0] flags,
                                 input logic send);
        wb_valid_in       = valid;
        opcode_in         = op;
        regbyte_in        = regb;
        rmbyte_in         = rmb;
        dep_in            = dep;
        alu_result_in     = res;
        alu_ext_result_in = ext;
        jump_flag_in      = jump;
        flags_we_in       = fwe;
        rflags_in         = flags;
        sim_end_in        = send;
        rip_in            = 64'h1000;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'd0, 4'd0, 4'd0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("reset_ready", wb_ready, 1);
        checkOutput("reset_rf_we", rf_we, 0);
        checkOutput("reset_flags", rflags_seq, 64'h2);
        checkOutput("reset_dep", dep_clear, 0);
        checkOutput("reset_sim_done", sim_done, 0);
        checkOutput("reset_redirect", redirect_valid, 0);
        reset = 1'b0;
        idleCycle();

        // Plain write to rm field
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd3, 2'd0, 64'h1234, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("mov_we", rf_we, 1);
        checkOutput("mov_waddr", rf_waddr, 3);
        checkOutput("mov_wdata", rf_wdata, 64'h1234);
        checkOutput("mov_dep", dep_clear, 16'h1000);
        idleCycle();
        checkOutput("idle_we", rf_we, 0);
        checkOutput("idle_dep", dep_clear, 0);

        // Destination from reg field when dep == 2
        applyStimulus(1'b1, 8'd1, 4'd9, 4'd1, 2'd2, 64'hABCD, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("regdst_waddr", rf_waddr, 9);
        checkOutput("regdst_dep", dep_clear, 16'h0040);

        // IMUL with a second beat held by execute during the stall
        applyStimulus(1'b1, 8'd247, 4'd0, 4'd0, 2'd0, 64'h6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("imul_lo_we", rf_we, 1);
        checkOutput("imul_lo_waddr", rf_waddr, 0);
        checkOutput("imul_lo_wdata", rf_wdata, 64'h6);
        checkOutput("imul_lo_dep", dep_clear, 16'h8000);
        checkOutput("imul_stall_ready", wb_ready, 0);
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd7, 2'd0, 64'h77, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("imul_hi_we", rf_we, 1);
        checkOutput("imul_hi_waddr", rf_waddr, 2);
        checkOutput("imul_hi_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("imul_hi_dep", dep_clear, 16'h2000);
        checkOutput("imul_hi_ready", wb_ready, 1);
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd7, 2'd0, 64'h77, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("held_waddr", rf_waddr, 7);
        checkOutput("held_wdata", rf_wdata, 64'h77);
        idleCycle();

        // CMP group: flags only, reserved bits sanitised
        applyStimulus(1'b1, 8'd129, 4'd7, 4'd4, 2'd0, 64'h5, 64'd0, 1'b0, 1'b1, 64'h68, 1'b0);
        checkOutput("cmp_we", rf_we, 0);
        checkOutput("cmp_flags", rflags_seq, 64'h42);
        // flags_we low leaves RFLAGS alone but still writes
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd1, 2'd0, 64'h9, 64'd0, 1'b0, 1'b0, 64'hFFFF, 1'b0);
        checkOutput("noflag_flags", rflags_seq, 64'h42);
        checkOutput("noflag_we", rf_we, 1);
        applyStimulus(1'b1, 8'd83, 4'd0, 4'd3, 2'd0, 64'h9, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("push_we", rf_we, 0);
        applyStimulus(1'b1, 8'd5, 4'd0, 4'd3, 2'd0, 64'h9, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("syscall_we", rf_we, 0);

        // Taken JE
        applyStimulus(1'b1, 8'd116, 4'd0, 4'd0, 2'd0, 64'h400100, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("je_redirect", redirect_valid, 1);
        checkOutput("je_pc", redirect_pc, 64'h400100);
        checkOutput("je_we", rf_we, 0);
        idleCycle();
        checkOutput("je_pulse_end", redirect_valid, 0);

        // Reset while the high half is pending
        applyStimulus(1'b1, 8'd247, 4'd0, 4'd0, 2'd0, 64'h3, 64'h99, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("rst_imul_lo", rf_we, 1);
        reset = 1'b1;
        idleCycle();
        checkOutput("rst_mid_we", rf_we, 0);
        checkOutput("rst_mid_ready", wb_ready, 1);
        checkOutput("rst_mid_waddr", rf_waddr, 0);
        checkOutput("rst_mid_wdata", rf_wdata, 0);
        checkOutput("rst_mid_flags", rflags_seq, 64'h2);
        checkOutput("rst_mid_dep", dep_clear, 0);
        reset = 1'b0;
        idleCycle();
        checkOutput("rst_no_rdx", rf_we, 0);

        // Final instruction, then further beats are blocked
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd5, 2'd0, 64'h55, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("end_we", rf_we, 1);
        checkOutput("end_waddr", rf_waddr, 5);
        checkOutput("end_ready", wb_ready, 0);
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd6, 2'd0, 64'h66, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("done_we", rf_we, 0);
        checkOutput("done_flag", sim_done, 1);
        checkOutput("done_ready", wb_ready, 0);
        applyStimulus(1'b1, 8'd199, 4'd0, 4'd6, 2'd0, 64'h66, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("done_we2", rf_we, 0);
        checkOutput("done_sticky", sim_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
